// File: rtl/pipe_accum.sv
// ---------------------------------------------------------------------------
// pipe_accum
// Sums the signed 16-bit product stream from the add/multiply pipe. Each
// block covers BLOCK_LEN accepted samples and uses a saturating signed
// accumulator. The finished sum is held on a valid/ready output until
// downstream takes it. A sticky flag reports whether any add in the block
// clamped.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (priority over everything)
//   d_in       signed sample from the multiply stage
//   in_valid   d_in is valid this cycle
//   in_ready   block is accepting samples (high while accumulating)
//   clear      synchronous abort of the block in progress (ignored in HOLD)
//   sum_out    signed, clamped block sum (valid with out_valid)
//   sat        some add in the block saturated (valid with out_valid)
//   out_valid  sum_out/sat hold a finished block
//   out_ready  downstream takes the result on this edge
// All outputs are registers; there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module pipe_accum #(
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = $clog2(BLOCK_LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      d_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat_int;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             sat_next;
  logic             last;

  // One guard bit past ACC_W makes overflow visible. If the top two bits of
  // the widened sum differ, the true result is outside the ACC_W range. The
  // guard bit then gives the sign of the true result, which selects the clamp.
  // NOTE: every always_comb output gets a default at the top of the block so
  // that no path leaves it unassigned; this is what keeps latches from being
  // inferred.
  always_comb begin
    sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W+1-16){d_in[15]}}, d_in};
    acc_next = sum_ext[ACC_W-1:0];
    sat_next = sat_int;
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_next = 1'b1;
    end
  end

  assign last = (count == LAST_CNT);

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ACC;
      acc       <= '0;
      count     <= '0;
      sat_int   <= 1'b0;
      sum_out   <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          // clear beats a sample arriving on the same edge
          if (clear) begin
            acc     <= '0;
            count   <= '0;
            sat_int <= 1'b0;
          end else if (in_valid) begin
            if (last) begin
              sum_out   <= acc_next;
              sat       <= sat_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              acc     <= acc_next;
              count   <= count + CNT_W'(1);
              sat_int <= sat_next;
            end
          end
        end
        ST_HOLD: begin
          // The held result is not changed by clear or by incoming samples.
          // The block state is cleared on the handoff edge, so the next block
          // starts from zero.
          if (out_ready) begin
            state     <= ST_ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            count     <= '0;
            sat_int   <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_accum.sv
// ---------------------------------------------------------------------------
// tb_pipe_accum
// Drives two pipe_accum instances from a single shared stimulus stream:
//   unit 0: BLOCK_LEN=4, ACC_W=24   unit 1: BLOCK_LEN=8, ACC_W=18
// A reference model tracks each unit's block in progress with plain integer
// arithmetic. When a block completes, the model pushes the expected result
// into that unit's queue. A monitor pops the queue and compares whenever the
// DUT presents a result.
// ---------------------------------------------------------------------------
module tb_pipe_accum;

  typedef struct {
    longint sum;
    bit     sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] d_in = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, sat_a, out_valid_a;
  logic [23:0] sum_a;
  logic        in_ready_b, sat_b, out_valid_b;
  logic [17:0] sum_b;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  // reference model state, per unit
  int     blk_len [2] = '{4, 8};
  int     acc_w   [2] = '{24, 18};
  bit     m_hold  [2];
  int     m_cnt   [2];
  longint m_acc   [2];
  bit     m_sat   [2];
  bit     known = 1'b0;
  bit     after_reset = 1'b0;

  pipe_accum #(.BLOCK_LEN(4), .ACC_W(24)) dut_a (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready_a), .clear(clear), .sum_out(sum_a), .sat(sat_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  pipe_accum #(.BLOCK_LEN(8), .ACC_W(18)) dut_b (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .clear(clear), .sum_out(sum_b), .sat(sat_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advances one unit's model by one clock edge.
  task automatic model_edge(int u, bit r, bit v, longint d, bit c, bit o);
    longint lim;
    exp_t   e;
    lim = longint'(1) << (acc_w[u] - 1);
    if (r) begin
      m_hold[u] = 0; m_cnt[u] = 0; m_acc[u] = 0; m_sat[u] = 0;
      if (u == 0) qa.delete(); else qb.delete();
    end else if (m_hold[u]) begin
      if (o) m_hold[u] = 0;
    end else if (c) begin
      m_cnt[u] = 0; m_acc[u] = 0; m_sat[u] = 0;
    end else if (v) begin
      m_acc[u] += d;
      if (m_acc[u] > lim - 1) begin m_acc[u] = lim - 1; m_sat[u] = 1; end
      if (m_acc[u] < -lim)    begin m_acc[u] = -lim;    m_sat[u] = 1; end
      m_cnt[u]++;
      if (m_cnt[u] == blk_len[u]) begin
        e.sum = m_acc[u];
        e.sat = m_sat[u];
        if (u == 0) qa.push_back(e); else qb.push_back(e);
        m_hold[u] = 1; m_cnt[u] = 0; m_acc[u] = 0; m_sat[u] = 0;
      end
    end
  endtask

  // One clock cycle: apply inputs, check handshake levels mid-cycle, then
  // let the edge happen and advance the model.
  task automatic step(bit r, bit v, logic signed [15:0] d, bit c, bit o);
    reset = r; in_valid = v; d_in = d; clear = c; out_ready = o;
    @(negedge clk);
    if (known) begin
      check("in_ready_a",  in_ready_a,  !m_hold[0]);
      check("out_valid_a", out_valid_a,  m_hold[0]);
      check("in_ready_b",  in_ready_b,  !m_hold[1]);
      check("out_valid_b", out_valid_b,  m_hold[1]);
      if (after_reset) begin
        check("reset_sum_a", sum_a, 0);
        check("reset_sat_a", sat_a, 0);
        check("reset_sum_b", sum_b, 0);
        check("reset_sat_b", sat_b, 0);
      end
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_edge(u, r, v, longint'(d), c, o);
    if (r) known = 1'b1;
    after_reset = r;
    #1;
  endtask

  task automatic feed(logic signed [15:0] d);
    step(0, 1, d, 0, 1);
  endtask

  // Monitor: every cycle a DUT presents a result, it must match the oldest
  // pending expectation. This also shows the result staying stable under
  // backpressure. The expectation is retired on the handshake.
  always @(negedge clk) begin
    if (known && !reset) begin
      if (out_valid_a) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out_a: out_valid=1 with sum=%0d, expected no result", $signed(sum_a));
        end else begin
          check("sum_a", $signed(sum_a), qa[0].sum);
          check("sat_a", sat_a, qa[0].sat);
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out_b: out_valid=1 with sum=%0d, expected no result", $signed(sum_b));
        end else begin
          check("sum_b", $signed(sum_b), qb[0].sum);
          check("sat_b", sat_b, qb[0].sat);
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  initial begin
    // basic sum: 100 - 50 + 200 + 7 = 257 on unit 0
    step(1, 0, 0, 0, 1);
    feed(100); feed(-50); feed(200); feed(7);
    repeat (3) step(0, 0, 0, 0, 1);

    // positive saturation, then a clean block of ones, on unit 1
    step(1, 0, 0, 0, 1);
    repeat (8) feed(16'sh7FFF);
    step(0, 0, 0, 0, 1);
    repeat (8) feed(1);
    repeat (3) step(0, 0, 0, 0, 1);

    // negative saturation on unit 1
    step(1, 0, 0, 0, 1);
    repeat (8) feed(-16'sd32768);
    repeat (3) step(0, 0, 0, 0, 1);

    // backpressure on unit 0: the 999 samples must not leak into the next block
    step(1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0); step(0, 1, 2, 0, 0);
    step(0, 1, 3, 0, 0); step(0, 1, 4, 0, 0);
    repeat (5) step(0, 1, 999, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (4) feed(5);
    repeat (3) step(0, 0, 0, 0, 1);

    // clear together with a sample drops that sample; clear in HOLD is ignored
    step(1, 0, 0, 0, 1);
    feed(10); feed(20);
    step(0, 1, 30, 1, 1);
    step(0, 1, 1, 0, 1); step(0, 1, 2, 0, 1);
    step(0, 1, 3, 0, 1); step(0, 1, 4, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // reset in the middle of a block
    step(1, 0, 0, 0, 1);
    feed(10); feed(20);
    step(1, 1, 30, 0, 1);
    repeat (4) feed(1);
    repeat (3) step(0, 0, 0, 0, 1);

    // randomized traffic, biased toward extremes so saturation recurs
    for (int i = 0; i < 1500; i++) begin
      logic signed [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'sh7FFF;
        1:       d = -16'sd32768;
        default: d = 16'($urandom);
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0));
    end

    // drain: every pending result must have been delivered
    repeat (20) step(0, 0, 0, 0, 1);
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
